// File: rtl/csi2_frame_arbiter_if.sv
// Purpose: single AXI-stream byte link carrying CSI-2 frames (tuser = frame start, tlast = frame end).
// Latency: none, wires only.
// Backpressure: standard valid/ready. The master holds its beat until tready.
// Ports: tvalid, tready, tdata[7:0], tlast, tuser; modport master drives the beat, modport slave drives tready.
interface csi2_frame_arbiter_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/csi2_frame_arbiter.sv
// Purpose: frame-granular round-robin arbiter merging two CSI-2 byte streams into one.
// Latency: grant is registered one cycle after selection; granted beats then pass through combinationally.
// Backpressure: granted requester sees m_axis.tready directly; the other requester is held (tready=0).
// Ports: clk, rst_n (sync, active-low); s0_axis/s1_axis requester streams (slave); m_axis arbitrated
//        stream (master); cfg_enable, err_clr controls; busy, active_src, err_len, err_sync,
//        frame_cnt0/frame_cnt1 status.
module csi2_frame_arbiter #(
    parameter int FRAME_BYTES = 8192,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    csi2_frame_arbiter_if.slave         s0_axis,
    csi2_frame_arbiter_if.slave         s1_axis,
    csi2_frame_arbiter_if.master        m_axis,
    input  logic                        cfg_enable,
    input  logic                        err_clr,
    output logic                        busy,
    output logic                        active_src,
    output logic                        err_len,
    output logic                        err_sync,
    output logic [15:0]                 frame_cnt0,
    output logic [15:0]                 frame_cnt1
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [14:0] FRAME_LEN = 15'(FRAME_BYTES);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES);

    state_t      state;
    logic        live;         // low for the first cycle after reset: no handshakes yet
    logic        granted_any;  // no grant since reset -> contention resolves to s0
    logic [13:0] beat_cnt;
    logic [15:0] gap_cnt;

    logic out_en;
    logic in_idle;
    logic in_grant;
    logic cand0;
    logic cand1;
    logic pick;
    logic acc;
    logic discard;
    logic len_evt;
    logic sync_evt;

    // rst_n gates combinationally so nothing handshakes while reset is held,
    // even before the first edge has initialised the state register.
    assign out_en   = rst_n & live;
    assign in_idle  = out_en & (state == IDLE);
    assign in_grant = out_en & (state == GRANT);

    assign cand0 = s0_axis.tvalid & s0_axis.tuser;
    assign cand1 = s1_axis.tvalid & s1_axis.tuser;
    assign pick  = (cand0 & cand1) ? (granted_any ? ~active_src : 1'b0) : cand1;

    // Zero-latency passthrough of the granted requester.
    assign m_axis.tvalid = in_grant & (active_src ? s1_axis.tvalid : s0_axis.tvalid);
    assign m_axis.tdata  = active_src ? s1_axis.tdata : s0_axis.tdata;
    assign m_axis.tlast  = in_grant & (active_src ? s1_axis.tlast : s0_axis.tlast);
    assign m_axis.tuser  = in_grant & (active_src ? s1_axis.tuser : s0_axis.tuser);

    // In IDLE, beats without a frame-start marker are swallowed so a requester
    // that lost sync cannot wedge the arbiter; frame heads wait for a grant.
    assign s0_axis.tready = in_grant ? (~active_src & m_axis.tready)
                                     : (in_idle & s0_axis.tvalid & ~s0_axis.tuser);
    assign s1_axis.tready = in_grant ? (active_src & m_axis.tready)
                                     : (in_idle & s1_axis.tvalid & ~s1_axis.tuser);

    assign acc     = m_axis.tvalid & m_axis.tready;
    assign discard = in_idle & ((s0_axis.tvalid & ~s0_axis.tuser) |
                                (s1_axis.tvalid & ~s1_axis.tuser));

    // Saturated count plus one never equals a legal length, so runaway frames still flag.
    assign len_evt  = acc & m_axis.tlast & (({1'b0, beat_cnt} + 15'd1) != FRAME_LEN);
    assign sync_evt = discard | (acc & m_axis.tuser & (beat_cnt != 14'd0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            live        <= 1'b0;
            granted_any <= 1'b0;
            active_src  <= 1'b0;
            busy        <= 1'b0;
            beat_cnt    <= 14'd0;
            gap_cnt     <= 16'd0;
            err_len     <= 1'b0;
            err_sync    <= 1'b0;
            frame_cnt0  <= 16'd0;
            frame_cnt1  <= 16'd0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_idle && cfg_enable && (cand0 || cand1)) begin
                        state       <= GRANT;
                        busy        <= 1'b1;
                        active_src  <= pick;
                        granted_any <= 1'b1;
                        beat_cnt    <= 14'd0;
                    end
                end
                GRANT: begin
                    if (acc) begin
                        if (beat_cnt != 14'h3fff) begin
                            beat_cnt <= beat_cnt + 14'd1;
                        end
                        if (m_axis.tlast) begin
                            if (active_src) begin
                                frame_cnt1 <= frame_cnt1 + 16'd1;
                            end else begin
                                frame_cnt0 <= frame_cnt0 + 16'd1;
                            end
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= GAP_LOAD;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // A new error in the clearing cycle keeps the flag set.
            err_len  <= len_evt  | (err_len  & ~err_clr);
            err_sync <= sync_evt | (err_sync & ~err_clr);
        end
    end
endmodule

// File: tb/tb_csi2_frame_arbiter.sv
// Purpose: randomized bench for csi2_frame_arbiter against a frame-level reference model.
// Latency: checks beats in order per source, with the grant order predicted by the round-robin rule.
// Backpressure: random upstream valid and downstream ready, AXI-stable drivers.
module tb_csi2_frame_arbiter;
    localparam int FRAME_BYTES = 8192;
    localparam int GAP_CYCLES  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic        err_clr;
    logic        busy;
    logic        active_src;
    logic        err_len;
    logic        err_sync;
    logic [15:0] frame_cnt0;
    logic [15:0] frame_cnt1;

    csi2_frame_arbiter_if s0_axis();
    csi2_frame_arbiter_if s1_axis();
    csi2_frame_arbiter_if m_axis();

    csi2_frame_arbiter #(.FRAME_BYTES(FRAME_BYTES), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_axis    (s0_axis),
        .s1_axis    (s1_axis),
        .m_axis     (m_axis),
        .cfg_enable (cfg_enable),
        .err_clr    (err_clr),
        .busy       (busy),
        .active_src (active_src),
        .err_len    (err_len),
        .err_sync   (err_sync),
        .frame_cnt0 (frame_cnt0),
        .frame_cnt1 (frame_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t e0[$];
    beat_t e1[$];
    int    eord[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_last;
    bit m_any;
    int mf0;
    int mf1;
    bit m_err_len;
    bit m_err_sync;

    // stimulus knobs and monitor state
    int vpct = 100;
    int rpct = 100;
    bit in_frame;
    int cur;
    int sb_err;
    int nout;
    int cyc;
    int last_tlast_cyc;
    int gap_meas;
    bit saw_tlast;
    bit smp_mvld;
    bit smp_s0rdy;
    bit smp_s1rdy;
    bit smp_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round robin: on contention grant the source not granted last; first contention goes to s0.
    function automatic int rr_pick(input bit c0, input bit c1);
        if (c0 && c1) return m_any ? (m_last ? 0 : 1) : 0;
        return c1 ? 1 : 0;
    endfunction

    task automatic grant(input int src);
        m_last = src[0];
        m_any  = 1'b1;
        eord.push_back(src);
    endtask

    task automatic add_frame(input int src, input int len, input int dup_user_at);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = 8'($urandom);
            b.u = (i == 0) || (i == dup_user_at);
            b.l = (i == len - 1);
            if (src == 0) begin q0.push_back(b); e0.push_back(b); end
            else          begin q1.push_back(b); e1.push_back(b); end
        end
        if (len != FRAME_BYTES) m_err_len = 1'b1;
        if (dup_user_at > 0 && dup_user_at < len) m_err_sync = 1'b1;
        if (src == 0) mf0++; else mf1++;
    endtask

    task automatic flush_all();
        q0.delete(); q1.delete(); e0.delete(); e1.delete(); eord.delete();
        s0_axis.tvalid = 1'b0;
        s1_axis.tvalid = 1'b0;
        in_frame = 1'b0;
        m_last = 1'b0; m_any = 1'b0; mf0 = 0; mf1 = 0;
        m_err_len = 1'b0; m_err_sync = 1'b0;
    endtask

    // One clock: sample and score at the falling edge, then drive after the rising edge.
    task automatic cycle();
        bit    hs0;
        bit    hs1;
        beat_t b;
        beat_t x;
        @(negedge clk);
        cyc++;
        smp_mvld  = m_axis.tvalid;
        smp_s0rdy = s0_axis.tready;
        smp_s1rdy = s1_axis.tready;
        smp_busy  = busy;
        hs0 = s0_axis.tvalid & s0_axis.tready;
        hs1 = s1_axis.tvalid & s1_axis.tready;
        saw_tlast = 1'b0;
        if (m_axis.tvalid && m_axis.tready) begin
            b.d = m_axis.tdata;
            b.u = m_axis.tuser;
            b.l = m_axis.tlast;
            if (!in_frame) begin
                in_frame = 1'b1;
                gap_meas = cyc - last_tlast_cyc;
                if (eord.size() == 0) begin sb_err++; cur = 0; end
                else cur = eord.pop_front();
            end
            if (cur == 0) begin
                if (e0.size() == 0) sb_err++;
                else begin x = e0.pop_front(); if (x != b) sb_err++; end
            end else begin
                if (e1.size() == 0) sb_err++;
                else begin x = e1.pop_front(); if (x != b) sb_err++; end
            end
            nout++;
            if (b.l) begin in_frame = 1'b0; last_tlast_cyc = cyc; saw_tlast = 1'b1; end
        end
        @(posedge clk);
        #1;
        if (hs0) x = q0.pop_front();
        if (hs1) x = q1.pop_front();
        if (saw_tlast) err_clr = 1'b0;
        if (q0.size() > 0 && ((s0_axis.tvalid && !hs0) || $urandom_range(99) < vpct)) begin
            s0_axis.tvalid = 1'b1;
            {s0_axis.tdata, s0_axis.tuser, s0_axis.tlast} = q0[0];
        end else begin
            s0_axis.tvalid = 1'b0;
        end
        if (q1.size() > 0 && ((s1_axis.tvalid && !hs1) || $urandom_range(99) < vpct)) begin
            s1_axis.tvalid = 1'b1;
            {s1_axis.tdata, s1_axis.tuser, s1_axis.tlast} = q1[0];
        end else begin
            s1_axis.tvalid = 1'b0;
        end
        m_axis.tready = ($urandom_range(99) < rpct);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || e0.size() > 0 || e1.size() > 0 ||
                eord.size() > 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, (n >= budget), 0);
    endtask

    task automatic run_to_tlast(input string tag, input int budget);
        int n = 0;
        do begin cycle(); n++; end while (!saw_tlast && n < budget);
        chk({tag, "_tlast_timeout"}, (n >= budget), 0);
    endtask

    task automatic run_to_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (nout < target && n < budget) begin cycle(); n++; end
        chk({tag, "_beats_timeout"}, (n >= budget), 0);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        m_err_len  = 1'b0;
        m_err_sync = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int hi;
        int leak;
        int s;
        beat_t j;

        rst_n = 1'b0; cfg_enable = 1'b1; err_clr = 1'b0;
        s0_axis.tvalid = 1'b0; s0_axis.tdata = 8'd0; s0_axis.tuser = 1'b0; s0_axis.tlast = 1'b0;
        s1_axis.tvalid = 1'b0; s1_axis.tdata = 8'd0; s1_axis.tuser = 1'b0; s1_axis.tlast = 1'b0;
        m_axis.tready = 1'b1;
        flush_all();
        sb_err = 0; nout = 0; cyc = 0; last_tlast_cyc = 0; gap_meas = 0;

        // reset state
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_active_src", active_src, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_frame_cnt0", frame_cnt0, 0);
        chk("rst_frame_cnt1", frame_cnt1, 0);
        chk("rst_m_tvalid", smp_mvld, 0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_busy", smp_busy, 0);

        // full-length s0 frame, no backpressure, then the forced gap
        add_frame(0, FRAME_BYTES, -1); grant(0);
        mark = nout;
        run_to_tlast("t1", 9000);
        hi = 0;
        for (int k = 0; k < GAP_CYCLES; k++) begin
            cycle();
            if (smp_busy && !smp_mvld) hi++;
        end
        chk("t1_gap_busy_hi", hi, GAP_CYCLES);
        cycle();
        chk("t1_gap_busy_lo", smp_busy, 0);
        drain("t1", 100);
        chk("t1_beats", nout - mark, FRAME_BYTES);
        chk("t1_scoreboard", sb_err, 0); sb_err = 0;
        chk("t1_frame_cnt0", frame_cnt0, mf0);
        chk("t1_err_len", err_len, m_err_len);

        // contention right after reset: s0 first, gap, s1; then third contention
        rst_n = 1'b0; cycle(); cycle(); rst_n = 1'b1; cycle();
        flush_all();
        add_frame(0, 64, -1); add_frame(1, 64, -1);
        s = rr_pick(1'b1, 1'b1); grant(s); grant(1 - s);
        drain("t2a", 1000);
        // gap cycles plus the registered selection cycle plus the beat cycle itself
        chk("t2_gap", gap_meas, GAP_CYCLES + 2);
        add_frame(0, 64, -1); add_frame(1, 64, -1);
        s = rr_pick(1'b1, 1'b1); grant(s); grant(1 - s);
        drain("t2b", 1000);
        chk("t2_scoreboard", sb_err, 0); sb_err = 0;
        chk("t2_frame_cnt0", frame_cnt0, mf0);
        chk("t2_frame_cnt1", frame_cnt1, mf1);
        chk("t2_err_len", err_len, m_err_len);

        // short s1 frame flags length error; clear; set beats clear
        clr_pulse(); cycle();
        chk("t3_clr_first", err_len, m_err_len);
        add_frame(1, 8000, -1); grant(1);
        drain("t3", 9000);
        chk("t3_err_len_set", err_len, m_err_len);
        chk("t3_frame_cnt1", frame_cnt1, mf1);
        clr_pulse(); cycle();
        chk("t3_err_len_clr", err_len, m_err_len);
        add_frame(1, 10, -1); grant(1);
        err_clr = 1'b1;   // held until the tlast beat is taken
        drain("t3w", 200);
        err_clr = 1'b0;
        chk("t3_set_wins", err_len, 1);
        chk("t3_scoreboard", sb_err, 0); sb_err = 0;
        clr_pulse();

        // random upstream gaps and 50% downstream backpressure over a full frame
        vpct = 90; rpct = 50;
        add_frame(0, FRAME_BYTES, -1); grant(0);
        mark = nout;
        drain("t4", 40000);
        vpct = 100; rpct = 100;
        chk("t4_beats", nout - mark, FRAME_BYTES);
        chk("t4_scoreboard", sb_err, 0); sb_err = 0;
        chk("t4_err_len", err_len, m_err_len);
        chk("t4_frame_cnt0", frame_cnt0, mf0);

        // stray beat in IDLE is discarded; tuser mid-frame is forwarded and flagged
        mark = nout;
        j.d = 8'hA5; j.u = 1'b0; j.l = 1'b0;
        q1.push_back(j); m_err_sync = 1'b1;
        repeat (4) cycle();
        chk("t5_discarded", q1.size(), 0);
        chk("t5_no_output", nout - mark, 0);
        chk("t5_err_sync", err_sync, m_err_sync);
        clr_pulse(); cycle();
        chk("t5_sync_clr", err_sync, m_err_sync);
        add_frame(0, 20, 10); grant(0);
        drain("t5", 300);
        chk("t5_mid_tuser", err_sync, m_err_sync);
        chk("t5_scoreboard", sb_err, 0); sb_err = 0;

        // cfg_enable dropped mid-frame: frame completes, pending s1 waits
        add_frame(0, 300, -1); grant(0);
        mark = nout;
        run_to_beats("t6", mark + 100, 1000);
        cfg_enable = 1'b0;
        add_frame(1, 50, -1); grant(1);
        run_to_tlast("t6", 1000);
        chk("t6_s0_beats", nout - mark, 300);
        leak = 0;
        repeat (60) begin
            cycle();
            if (smp_s1rdy || smp_mvld) leak++;
        end
        chk("t6_held", leak, 0);
        chk("t6_pending", q1.size(), 50);
        cfg_enable = 1'b1;
        drain("t6", 500);
        chk("t6_scoreboard", sb_err, 0); sb_err = 0;
        chk("t6_frame_cnt1", frame_cnt1, mf1);

        // reset mid-frame at beat 4000, then a clean frame
        add_frame(0, FRAME_BYTES, -1); grant(0);
        mark = nout;
        run_to_beats("t7", mark + 4000, 5000);
        rst_n = 1'b0;
        cycle();
        chk("t7_rst_m_tvalid", smp_mvld, 0);
        chk("t7_rst_s0_tready", smp_s0rdy, 0);
        chk("t7_busy", busy, 0);
        chk("t7_active_src", active_src, 0);
        chk("t7_err_len", err_len, 0);
        chk("t7_err_sync", err_sync, 0);
        chk("t7_frame_cnt0", frame_cnt0, 0);
        chk("t7_frame_cnt1", frame_cnt1, 0);
        rst_n = 1'b1;
        cycle();
        chk("t7_first_s0_tready", smp_s0rdy, 0);
        chk("t7_first_m_tvalid", smp_mvld, 0);
        chk("t7_first_busy", smp_busy, 0);
        flush_all();
        add_frame(0, FRAME_BYTES, -1); grant(0);
        mark = nout;
        drain("t7", 9000);
        chk("t7_beats", nout - mark, FRAME_BYTES);
        chk("t7_scoreboard", sb_err, 0); sb_err = 0;
        chk("t7_new_err_len", err_len, m_err_len);
        chk("t7_new_frame_cnt0", frame_cnt0, mf0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csi2_frame_arbiter.md
CSI2_FRAME_ARBITER -- requirements
Module: csi2_frame_arbiter

Interface
REQ-001 Parameter FRAME_BYTES, default 8192, expected beats per frame (16 lines x 512 bytes).
REQ-002 Parameter GAP_CYCLES, default 16, idle cycles forced between frames (0 allowed).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 s0_axis_tvalid/tready/tdata[7:0]/tlast/tuser  in/out/in/in/in  1/1/8/1/1  requester 0 frame stream (tuser = frame start, tlast = frame end).
REQ-006 s1_axis_tvalid/tready/tdata[7:0]/tlast/tuser  same as REQ-005  requester 1 frame stream.
REQ-007 m_axis_tvalid/tready/tdata[7:0]/tlast/tuser  out/in/out/out/out  1/1/8/1/1  arbitrated stream to csi2_tx_top.
REQ-008 cfg_enable  input  1  1 = grant new frames; 0 = finish current frame, then hold idle.
REQ-009 err_clr  input  1  single-cycle pulse clearing sticky error flags.
REQ-010 busy  output  1  high in GRANT or GAP.
REQ-011 active_src  output  1  requester currently or last granted.
REQ-012 err_len  output  1  sticky; frame ended with beat count != FRAME_BYTES.
REQ-013 err_sync  output  1  sticky; beat without tuser in IDLE, or tuser mid-frame.
REQ-014 frame_cnt0, frame_cnt1  output  16 each  completed frames per requester.

Function
REQ-015 FSM states IDLE, GRANT, GAP; reset state IDLE.
REQ-016 IDLE: candidate = requester with tvalid=1 and tuser=1; cfg_enable=0 blocks all grants.
REQ-017 Round robin: both candidates -> grant the one not equal to active_src; first contention after reset -> s0.
REQ-018 Grant takes effect the cycle after selection (IDLE->GRANT registered); no beat passes in the selecting cycle.
REQ-019 IDLE, tvalid=1 with tuser=0 on any requester: tready=1, beat discarded, err_sync set.
REQ-020 GRANT: m_axis_tvalid/tdata/tlast/tuser = granted requester's inputs combinationally; granted tready = m_axis_tready; zero added latency.
REQ-021 Non-granted requester tready=0 in GRANT and GAP; its data held upstream, never dropped.
REQ-022 GRANT: 14-bit beat counter increments per accepted beat (tvalid&tready), saturates at 16383, clears on GRANT entry.
REQ-023 Accepted beat with tlast: counter+1 != FRAME_BYTES sets err_len; frame_cntN of granted source increments (wraps 0xFFFF->0); FSM -> GAP (GAP_CYCLES>0) or IDLE.
REQ-024 Accepted beat with tuser=1 after the first beat of a frame: forwarded unchanged, err_sync set.
REQ-025 GAP: down-counter loaded with GAP_CYCLES on entry; m_axis_tvalid=0; -> IDLE when counter reaches 1 (exactly GAP_CYCLES cycles in GAP).
REQ-026 cfg_enable falling mid-frame does not truncate the frame; deassertion only blocks the next grant.
REQ-027 err_clr and same-cycle error event: set wins.
REQ-028 m_axis outputs never change while m_axis_tvalid=1 and m_axis_tready=0 (guaranteed by passthrough plus AXI-compliant requesters).

Reset
REQ-029 rst_n=0 at a clock edge: state IDLE, active_src=0, counters 0, err_len=0, err_sync=0, frame_cnt0/1=0.
REQ-030 During reset and first cycle after: m_axis_tvalid=0, s0/s1 tready=0, busy=0.
REQ-031 Reset mid-frame abandons the frame with no tlast emitted; downstream resynchronises on next tuser.

Verification
REQ-032 s0 sends 8192-beat frame (tuser on beat 0, tlast on 8191), m_tready=1 -> 8192 beats out, frame_cnt0=1, err_len=0, busy low 16 cycles after tlast.
REQ-033 s0 and s1 both present tuser in same IDLE cycle after reset -> s0 frame out first, then 16-cycle gap, then s1 frame; third contention -> s0.
REQ-034 s1 frame of 8000 beats -> err_len=1 at tlast; err_clr pulse -> err_len=0.
REQ-035 Random m_tready backpressure (50%) over one frame -> output sequence matches s0 input byte-for-byte, no beat lost or duplicated.
REQ-036 cfg_enable dropped at beat 100 of s0 frame -> frame completes to tlast; pending s1 not granted until cfg_enable=1.
REQ-037 rst_n low at beat 4000 -> next cycle all status 0, m_tvalid=0; new s0 frame after release passes with err_len=0.
